acc_drain: RTL and testbench

//  Output-side counterpart of the ffn input skew feeder. Takes the column-skewed

---
 rtl/acc_drain.sv | 164 ++++++++++++++++
 tb/tb_acc_drain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain.sv
// Deskews the column-skewed accumulator outputs of the systolic array, requantizes
// each column to DATA_WIDTH with saturation and writes one aligned row per vector.
module acc_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 64,
    parameter int NEURON_NUM = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int FRAC_BITS  = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start_i,
    input  logic [ADDR_WIDTH:0]              rows_i,
    input  logic [ADDR_WIDTH-1:0]            base_addr_i,
    input  logic [ACC_WIDTH*NEURON_NUM-1:0]  acc_i,
    input  logic                             acc_valid_i,
    output logic                             wr_en_o,
    output logic [ADDR_WIDTH-1:0]            wr_addr_o,
    output logic [DATA_WIDTH*NEURON_NUM-1:0] wr_data_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             ovf_o
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t                                    r_state;
    state_t                                    w_state_next;
    logic                                      w_start_acc;
    logic                                      w_wr_acc;
    logic                                      w_aligned_valid;
    logic [ADDR_WIDTH:0]                       r_rows;
    logic [ADDR_WIDTH:0]                       r_count;
    logic [ADDR_WIDTH-1:0]                     r_base;
    logic                                      r_wr_en;
    logic [ADDR_WIDTH-1:0]                     r_wr_addr;
    logic [DATA_WIDTH*NEURON_NUM-1:0]          r_wr_data;
    logic                                      r_busy;
    logic                                      r_done;
    logic                                      r_ovf;
    logic                                      r_vld [NEURON_NUM-1];
    logic [ACC_WIDTH-1:0]                      w_aligned [NEURON_NUM];
    logic [NEURON_NUM-1:0][DATA_WIDTH-1:0]     w_q;
    logic [NEURON_NUM-1:0]                     w_clamp;

    // Column j arrives j cycles after column 0, so it is delayed NEURON_NUM-1-j stages.
    genvar gi;
    generate
        for (gi = 0; gi < NEURON_NUM; gi++) begin : g_col
            localparam int DEPTH = NEURON_NUM - 1 - gi;
            logic [ACC_WIDTH-1:0]        w_col_in;
            logic signed [ACC_WIDTH-1:0] w_shift;
            logic                        w_hi;
            logic                        w_lo;

            assign w_col_in = acc_i[ACC_WIDTH*(gi+1)-1 -: ACC_WIDTH];

            if (DEPTH == 0) begin : g_direct
                assign w_aligned[gi] = w_col_in;
            end else begin : g_dly
                logic [ACC_WIDTH-1:0] r_dly [DEPTH];
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        for (int k = 0; k < DEPTH; k++) r_dly[k] <= '0;
                    end else begin
                        r_dly[0] <= w_col_in;
                        for (int k = 1; k < DEPTH; k++) r_dly[k] <= r_dly[k-1];
                    end
                end
                assign w_aligned[gi] = r_dly[DEPTH-1];
            end

            assign w_shift     = $signed(w_aligned[gi]) >>> FRAC_BITS;
            assign w_hi        = w_shift > SAT_MAX;
            assign w_lo        = w_shift < SAT_MIN;
            assign w_clamp[gi] = w_hi | w_lo;
            assign w_q[gi]     = w_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                                 w_lo ? SAT_MIN[DATA_WIDTH-1:0] :
                                        w_shift[DATA_WIDTH-1:0];
        end
    endgenerate

    // Valid pipe is only fed while draining and is flushed on start so that
    // leftovers from a previous pass cannot leak into the new one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NEURON_NUM-1; k++) r_vld[k] <= 1'b0;
        end else if (w_start_acc) begin
            for (int k = 0; k < NEURON_NUM-1; k++) r_vld[k] <= 1'b0;
        end else begin
            r_vld[0] <= acc_valid_i && (r_state == S_DRAIN);
            for (int k = 1; k < NEURON_NUM-1; k++) r_vld[k] <= r_vld[k-1];
        end
    end

    assign w_aligned_valid = r_vld[NEURON_NUM-2];

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_wr_acc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_start_acc  = 1'b1;
                    w_state_next = (rows_i == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_aligned_valid) begin
                    w_wr_acc = 1'b1;
                    if (r_count + (ADDR_WIDTH+1)'(1) == r_rows) w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_rows    <= '0;
            r_count   <= '0;
            r_base    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wr_en <= w_wr_acc;
            r_busy  <= (w_state_next != S_IDLE);
            // done trails the DONE state by a cycle so it lands after the last write
            r_done  <= (r_state == S_DONE);
            if (w_start_acc) begin
                r_rows  <= rows_i;
                r_base  <= base_addr_i;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            if (w_wr_acc) begin
                r_wr_addr <= r_base + r_count[ADDR_WIDTH-1:0];
                r_wr_data <= w_q;
                r_count   <= r_count + (ADDR_WIDTH+1)'(1);
                if (|w_clamp) r_ovf <= 1'b1;
            end
        end
    end

    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: stimulus pushes expected writes into a scoreboard,
// a negedge monitor pops and compares every write and tracks done pulses.
module tb_acc_drain;
    localparam int DW  = 16;
    localparam int AW  = 64;
    localparam int NN  = 4;
    localparam int ADW = 4;

    typedef struct {
        logic [ADW-1:0]   a;
        logic [DW*NN-1:0] d;
        int               c;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic               start_i = 1'b0;
    logic [ADW:0]       rows_i = '0;
    logic [ADW-1:0]     base_addr_i = '0;
    logic [AW*NN-1:0]   acc_i = '0;
    logic               acc_valid_i = 1'b0;
    logic               wr_en_o;
    logic [ADW-1:0]     wr_addr_o;
    logic [DW*NN-1:0]   wr_data_o;
    logic               busy_o;
    logic               done_o;
    logic               ovf_o;

    acc_drain dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .rows_i(rows_i),
        .base_addr_i(base_addr_i), .acc_i(acc_i), .acc_valid_i(acc_valid_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_wr_cyc = -1;
    int          start_cyc = 0;
    int          d0 = 0;
    logic [3:0]  cur_base = '0;
    longint      acc_m [8][4];
    logic [15:0] exp_m [8][4];
    exp_t        sb [$];
    exp_t        mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (wr_en_o) begin
                last_wr_cyc = cyc;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, expected no write",
                             wr_addr_o, wr_data_o, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 64'(wr_addr_o), 64'(mon_e.a));
                    chk("wr_data", wr_data_o, mon_e.d);
                    chk("wr_cycle", 64'(cyc), 64'(mon_e.c));
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy_o), 64'd0);
            end
        end
    end

    function automatic logic [63:0] pack_row(input int r);
        logic [63:0] v;
        for (int j = 0; j < NN; j++) v[DW*j +: DW] = exp_m[r][j];
        return v;
    endfunction

    // Expected column values e0..e3; accumulator = value scaled by 2^8 plus a fraction.
    task automatic set_row(input int r, input int e0, input int e1, input int e2, input int e3,
                           input int frac);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int j = 0; j < NN; j++) begin
            exp_m[r][j] = 16'(e[j]);
            acc_m[r][j] = longint'(e[j]) * 256 + longint'(frac);
        end
    endtask

    task automatic pulse_start(input int rows, input int base);
        @(posedge clk); #1;
        start_i     = 1'b1;
        rows_i      = 5'(rows);
        base_addr_i = 4'(base);
        start_cyc   = cyc;
        d0          = done_cnt;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        @(posedge clk); #1;
    endtask

    // Drives n skewed rows (one start every gap+1 cycles); only the first n_exp are expected.
    task automatic drive_rows(input int n, input int n_exp, input int gap);
        int last;
        last = (n - 1) * (gap + 1) + NN - 1;
        for (int c = 0; c <= last; c++) begin
            acc_valid_i = 1'b0;
            acc_i       = '0;
            for (int r = 0; r < n; r++) begin
                if (c == r * (gap + 1)) begin
                    acc_valid_i = 1'b1;
                    if (r < n_exp) sb.push_back('{cur_base + 4'(r), pack_row(r), cyc + 4});
                end
                for (int j = 0; j < NN; j++)
                    if (c - j == r * (gap + 1)) acc_i[AW*j +: AW] = acc_m[r][j];
            end
            @(posedge clk); #1;
        end
        acc_valid_i = 1'b0;
        acc_i       = '0;
    endtask

    task automatic wait_done(input string nm);
        int i;
        i = 0;
        while (done_cnt == d0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 64'(done_cnt - d0), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // reset state
        #1 rstn = 1'b0;
        #3;
        chk("rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("rst_wr_data", wr_data_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // 1: single row, base 2, data {4,3,2,1}
        set_row(0, 1, 2, 3, 4, 0);
        cur_base = 4'd2;
        pulse_start(1, 2);
        drive_rows(1, 1, 0);
        wait_done("t1_done");
        chk("t1_done_after_wr", 64'(done_cyc), 64'(last_wr_cyc + 1));
        chk("t1_ovf", 64'(ovf_o), 64'd0);

        // 2: four contiguous rows from a golden matrix
        set_row(0, 1, 2, 3, 4, 85);
        set_row(1, -1, -2, 100, -300, 85);
        set_row(2, 32767, -32768, 0, 7, 85);
        set_row(3, 255, -256, 1000, -1000, 85);
        cur_base = 4'd0;
        pulse_start(4, 0);
        drive_rows(4, 4, 0);
        wait_done("t2_done");
        chk("t2_ovf", 64'(ovf_o), 64'd0);

        // 3: saturation in both directions
        acc_m[0][0] = 64'sd1 <<< 40;
        acc_m[0][1] = -(64'sd1 <<< 40);
        acc_m[0][2] = 64'sh100;
        acc_m[0][3] = 64'sh100;
        exp_m[0][0] = 16'h7fff;
        exp_m[0][1] = 16'h8000;
        exp_m[0][2] = 16'd1;
        exp_m[0][3] = 16'd1;
        cur_base = 4'd5;
        pulse_start(1, 5);
        drive_rows(1, 1, 0);
        wait_done("t3_done");
        chk("t3_ovf_set", 64'(ovf_o), 64'd1);
        repeat (3) @(posedge clk);
        #1 chk("t3_ovf_sticky", 64'(ovf_o), 64'd1);

        // 4: address wrap, gapped rows, extra valids before start and after last row
        acc_valid_i = 1'b1;
        acc_i       = {4{64'h0000_0000_0000_7700}};
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        acc_i       = '0;
        set_row(0, 10, 20, 30, 40, 3);
        set_row(1, -10, -20, -30, -40, 3);
        set_row(2, 11, 22, 33, 44, 3);
        set_row(3, 99, 99, 99, 99, 3);
        set_row(4, 77, 77, 77, 77, 3);
        cur_base = 4'd14;
        pulse_start(3, 14);
        chk("t4_ovf_cleared", 64'(ovf_o), 64'd0);
        drive_rows(5, 3, 1);
        wait_done("t4_done");

        // 5: zero rows, then a start ignored during DRAIN
        pulse_start(0, 0);
        wait_done("t5_done_rows0");
        chk("t5_done_latency", 64'(done_cyc), 64'(start_cyc + 2));
        set_row(0, 5, 6, 7, 8, 0);
        set_row(1, -5, -6, -7, -8, 0);
        cur_base = 4'd8;
        pulse_start(2, 8);
        pulse_start(1, 0);
        drive_rows(2, 2, 0);
        wait_done("t5_done_ignored_start");

        // 6: asynchronous reset after two of four rows
        set_row(0, 1, 1, 1, 1, 0);
        set_row(1, 2, 2, 2, 2, 0);
        set_row(2, 3, 3, 3, 3, 0);
        set_row(3, 4, 4, 4, 4, 0);
        cur_base = 4'd6;
        pulse_start(4, 6);
        t0 = cyc;
        d0 = done_cnt;
        fork
            drive_rows(4, 2, 0);
            begin
                while (cyc < t0 + 5) @(negedge clk);
                #2 rstn = 1'b0;
                #1;
                chk("t6_rst_wr_en", 64'(wr_en_o), 64'd0);
                chk("t6_rst_wr_data", wr_data_o, 64'd0);
                chk("t6_rst_busy", 64'(busy_o), 64'd0);
                @(posedge clk);
                @(posedge clk);
                #1 rstn = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);
        set_row(0, 123, -123, 456, -456, 200);
        set_row(1, 7, 8, 9, 10, 200);
        cur_base = 4'd1;
        pulse_start(2, 1);
        drive_rows(2, 2, 0);
        wait_done("t6_fresh_done");

        repeat (4) @(posedge clk);
        #1 chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
